// File: rtl/alu_request_arbiter.sv
// Two-port round-robin front end for one shared combinational ALU.
// Each accepted op is issued from registered operands for one cycle, and the
// captured result is then held on the owner's response channel until consumed.
module alu_request_arbiter #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           CTRL_WIDTH = 4,
  parameter logic [CTRL_WIDTH-1:0] ALU_ADD    = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  // Request port 0 (execute-stage issue)
  input  logic                  Req0_Valid,
  output logic                  Req0_Ready,
  input  logic [CTRL_WIDTH-1:0] Req0_ALU_Control,
  input  logic [DATA_WIDTH-1:0] Req0_SrcA,
  input  logic [DATA_WIDTH-1:0] Req0_SrcB,
  // Request port 1 (aux/debug issue)
  input  logic                  Req1_Valid,
  output logic                  Req1_Ready,
  input  logic [CTRL_WIDTH-1:0] Req1_ALU_Control,
  input  logic [DATA_WIDTH-1:0] Req1_SrcA,
  input  logic [DATA_WIDTH-1:0] Req1_SrcB,
  // Response port 0
  output logic                  Rsp0_Valid,
  input  logic                  Rsp0_Ready,
  output logic [DATA_WIDTH-1:0] Rsp0_Result,
  output logic                  Rsp0_Branch_Condition,
  // Response port 1
  output logic                  Rsp1_Valid,
  input  logic                  Rsp1_Ready,
  output logic [DATA_WIDTH-1:0] Rsp1_Result,
  output logic                  Rsp1_Branch_Condition,
  // Shared ALU
  output logic [CTRL_WIDTH-1:0] ALU_Control,
  output logic [DATA_WIDTH-1:0] SrcA,
  output logic [DATA_WIDTH-1:0] SrcB,
  input  logic [DATA_WIDTH-1:0] ALU_Result,
  input  logic                  ALU_Branch_Condition
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q, state_d;
  logic   last_grant_q;
  logic   owner_q;
  logic   grant;
  logic   accept;
  logic   owner_rsp_ready;

  // Round-robin pick: a lone requester always wins; on contention the port
  // that was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (Req0_Valid && Req1_Valid) begin
      grant = ~last_grant_q;
    end else if (Req1_Valid) begin
      grant = 1'b1;
    end
  end

  assign owner_rsp_ready = owner_q ? Rsp1_Ready : Rsp0_Ready;
  assign accept          = Req0_Ready | Req1_Ready;

  // Next-state and request-ready decode; readies only ever asserted in idle.
  always_comb begin
    state_d    = state_q;
    Req0_Ready = 1'b0;
    Req1_Ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Hold off acceptance while reset is asserted so nothing is taken
        // on a cycle that is about to be discarded.
        if (!RST && (Req0_Valid || Req1_Valid)) begin
          Req0_Ready = ~grant;
          Req1_Ready = grant;
          state_d    = StIssue;
        end
      end
      StIssue: state_d = StResp;
      StResp: begin
        if (owner_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, grant history and the operand registers that drive the ALU.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ALU_Control  <= ALU_ADD;
      SrcA         <= '0;
      SrcB         <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        ALU_Control  <= grant ? Req1_ALU_Control : Req0_ALU_Control;
        SrcA         <= grant ? Req1_SrcA : Req0_SrcA;
        SrcB         <= grant ? Req1_SrcB : Req0_SrcB;
      end
    end
  end

  // Response capture in issue, release on the owner's ready in resp.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Rsp0_Valid            <= 1'b0;
      Rsp0_Result           <= '0;
      Rsp0_Branch_Condition <= 1'b0;
      Rsp1_Valid            <= 1'b0;
      Rsp1_Result           <= '0;
      Rsp1_Branch_Condition <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        if (owner_q) begin
          Rsp1_Valid            <= 1'b1;
          Rsp1_Result           <= ALU_Result;
          Rsp1_Branch_Condition <= ALU_Branch_Condition;
        end else begin
          Rsp0_Valid            <= 1'b1;
          Rsp0_Result           <= ALU_Result;
          Rsp0_Branch_Condition <= ALU_Branch_Condition;
        end
      end
      if (state_q == StResp && owner_rsp_ready) begin
        if (owner_q) begin
          Rsp1_Valid <= 1'b0;
        end else begin
          Rsp0_Valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Self-checking bench for alu_request_arbiter: directed scenarios plus a
// randomized run scored against a transaction-level reference model.
module tb_alu_request_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic        CLK, RST;
  logic        Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
  logic [3:0]  Req0_ALU_Control, Req1_ALU_Control, ALU_Control;
  logic [31:0] Req0_SrcA, Req0_SrcB, Req1_SrcA, Req1_SrcB;
  logic        Rsp0_Valid, Rsp0_Ready, Rsp1_Valid, Rsp1_Ready;
  logic [31:0] Rsp0_Result, Rsp1_Result;
  logic        Rsp0_Branch_Condition, Rsp1_Branch_Condition;
  logic [31:0] SrcA, SrcB, ALU_Result;
  logic        ALU_Branch_Condition;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a + b;
    endcase
  endfunction

  // Stand-in for the shared combinational ALU; branch condition = zero result.
  assign ALU_Result           = alu_fn(ALU_Control, SrcA, SrcB);
  assign ALU_Branch_Condition = (ALU_Result == 32'h0);

  alu_request_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .ALU_ADD(OP_ADD)) dut (
    .CLK(CLK), .RST(RST),
    .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_ALU_Control(Req0_ALU_Control),
    .Req0_SrcA(Req0_SrcA), .Req0_SrcB(Req0_SrcB),
    .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_ALU_Control(Req1_ALU_Control),
    .Req1_SrcA(Req1_SrcA), .Req1_SrcB(Req1_SrcB),
    .Rsp0_Valid(Rsp0_Valid), .Rsp0_Ready(Rsp0_Ready), .Rsp0_Result(Rsp0_Result),
    .Rsp0_Branch_Condition(Rsp0_Branch_Condition),
    .Rsp1_Valid(Rsp1_Valid), .Rsp1_Ready(Rsp1_Ready), .Rsp1_Result(Rsp1_Result),
    .Rsp1_Branch_Condition(Rsp1_Branch_Condition),
    .ALU_Control(ALU_Control), .SrcA(SrcA), .SrcB(SrcB),
    .ALU_Result(ALU_Result), .ALU_Branch_Condition(ALU_Branch_Condition)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    Req0_Valid = 1'b0; Req0_ALU_Control = OP_ADD; Req0_SrcA = '0; Req0_SrcB = '0;
    Req1_Valid = 1'b0; Req1_ALU_Control = OP_ADD; Req1_SrcA = '0; Req1_SrcB = '0;
    Rsp0_Ready = 1'b0; Rsp1_Ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    clear_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    clear_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if ({Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_handshakes got=%b exp=0000",
               {Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid});
    end
    checks++;
    if ({ALU_Control, SrcA, SrcB} !== {OP_ADD, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_alu_outputs got=%h/%h/%h exp=%h/0/0", ALU_Control, SrcA, SrcB, OP_ADD);
    end
    checks++;
    if ({Rsp0_Result, Rsp1_Result, Rsp0_Branch_Condition, Rsp1_Branch_Condition} !== 66'h0) begin
      errors++;
      $display("FAIL reset_rsp_data got=%h/%h exp=0/0", Rsp0_Result, Rsp1_Result);
    end
    Req0_Valid = 1'b1;
    #1;
    checks++;
    if (Req0_Ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_blocks_ready got=%b exp=0", Req0_Ready);
    end
    @(negedge CLK);
    RST = 1'b0;
    Req0_Valid = 1'b0;
  endtask

  task automatic test_single_op();
    @(negedge CLK);
    Req0_Valid = 1'b1; Req0_ALU_Control = OP_ADD; Req0_SrcA = 32'h1; Req0_SrcB = 32'h1;
    Rsp0_Ready = 1'b1;
    #1;
    checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready got=%b exp=10", {Req0_Ready, Req1_Ready});
    end
    @(negedge CLK);
    Req0_Valid = 1'b0;
    #1;
    checks++;
    if ({Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid} !== 4'b0000) begin
      errors++;
      $display("FAIL single_issue_flags got=%b exp=0000",
               {Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid});
    end
    checks++;
    if ({ALU_Control, SrcA, SrcB} !== {OP_ADD, 32'h1, 32'h1}) begin
      errors++;
      $display("FAIL single_issue_operands got=%h/%h/%h exp=0/1/1", ALU_Control, SrcA, SrcB);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({Rsp0_Valid, Rsp1_Valid, Rsp0_Result, Rsp0_Branch_Condition} !== {2'b10, 32'h2, 1'b0})
    begin
      errors++;
      $display("FAIL single_response got=%b%b/%h/%b exp=10/00000002/0",
               Rsp0_Valid, Rsp1_Valid, Rsp0_Result, Rsp0_Branch_Condition);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({Rsp0_Valid, ALU_Control, SrcA, SrcB} !== {1'b0, OP_ADD, 32'h1, 32'h1}) begin
      errors++;
      $display("FAIL single_release_hold got=%b/%h/%h/%h exp=0/0/1/1",
               Rsp0_Valid, ALU_Control, SrcA, SrcB);
    end
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge CLK);
    Req0_Valid = 1'b1; Req0_ALU_Control = OP_SUB; Req0_SrcA = 32'h8000_0000; Req0_SrcB = 32'h1;
    Req1_Valid = 1'b1; Req1_ALU_Control = OP_ADD; Req1_SrcA = 32'hFFFF_FFFF;
    Req1_SrcB = 32'hFFFF_FFFF;
    Rsp0_Ready = 1'b1; Rsp1_Ready = 1'b1;
    #1;
    checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b10) begin
      errors++;
      $display("FAIL contention_first_grant got=%b exp=10", {Req0_Ready, Req1_Ready});
    end
    @(negedge CLK);
    Req0_Valid = 1'b0;
    #1;
    checks++;
    if ({Req1_Ready, Rsp0_Valid, Rsp1_Valid} !== 3'b000) begin
      errors++;
      $display("FAIL contention_issue got=%b exp=000", {Req1_Ready, Rsp0_Valid, Rsp1_Valid});
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({Req1_Ready, Rsp0_Valid, Rsp1_Valid, Rsp0_Result} !== {3'b010, 32'h7FFF_FFFF}) begin
      errors++;
      $display("FAIL contention_rsp0 got=%b/%h exp=010/7fffffff",
               {Req1_Ready, Rsp0_Valid, Rsp1_Valid}, Rsp0_Result);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid} !== 4'b0100) begin
      errors++;
      $display("FAIL contention_second_grant got=%b exp=0100",
               {Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid});
    end
    @(negedge CLK);
    Req1_Valid = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if ({Rsp0_Valid, Rsp1_Valid, Rsp1_Result, Rsp1_Branch_Condition}
        !== {2'b01, 32'hFFFF_FFFE, 1'b0}) begin
      errors++;
      $display("FAIL contention_rsp1 got=%b%b/%h/%b exp=01/fffffffe/0",
               Rsp0_Valid, Rsp1_Valid, Rsp1_Result, Rsp1_Branch_Condition);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({Rsp0_Valid, Rsp1_Valid} !== 2'b00) begin
      errors++;
      $display("FAIL contention_drain got=%b exp=00", {Rsp0_Valid, Rsp1_Valid});
    end
  endtask

  // Port 1 was served last, so port 0 wins; port 1 waits behind a stalled response.
  task automatic test_back_pressure();
    @(negedge CLK);
    Req0_Valid = 1'b1; Req0_ALU_Control = OP_ADD; Req0_SrcA = 32'h5; Req0_SrcB = 32'h7;
    Req1_Valid = 1'b1; Req1_ALU_Control = OP_SUB; Req1_SrcA = 32'h9; Req1_SrcB = 32'h9;
    Rsp0_Ready = 1'b0; Rsp1_Ready = 1'b1;
    #1;
    checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b10) begin
      errors++;
      $display("FAIL bp_grant got=%b exp=10", {Req0_Ready, Req1_Ready});
    end
    @(negedge CLK);
    Req0_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      checks++;
      if ({Rsp0_Valid, Rsp1_Valid, Req1_Ready, Rsp0_Result} !== {3'b100, 32'hC}) begin
        errors++;
        $display("FAIL bp_stall cycle=%0d got=%b/%h exp=100/0000000c", i,
                 {Rsp0_Valid, Rsp1_Valid, Req1_Ready}, Rsp0_Result);
      end
    end
    Rsp0_Ready = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if ({Rsp0_Valid, Req1_Ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got=%b exp=01", {Rsp0_Valid, Req1_Ready});
    end
    @(negedge CLK);
    Req1_Valid = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if ({Rsp1_Valid, Rsp1_Result, Rsp1_Branch_Condition} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL bp_queued_op got=%b/%h/%b exp=1/00000000/1",
               Rsp1_Valid, Rsp1_Result, Rsp1_Branch_Condition);
    end
    @(negedge CLK);
  endtask

  // Both ports request back to back, two ops each; expected order 0,1,0,1.
  task automatic test_fairness();
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          grants = 0;
    int          left0 = 2, left1 = 2;
    int          seq[4];
    bit          acc0 = 0, acc1 = 0, done = 0;
    @(negedge CLK);
    Req0_Valid = 1'b1; Req0_ALU_Control = OP_XOR; Req0_SrcA = $urandom; Req0_SrcB = $urandom;
    Req1_Valid = 1'b1; Req1_ALU_Control = OP_SUB; Req1_SrcA = $urandom; Req1_SrcB = $urandom;
    Rsp0_Ready = 1'b1; Rsp1_Ready = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge CLK);
        if (acc0) begin
          if (left0 > 0) begin Req0_SrcA = $urandom; Req0_SrcB = $urandom; end
          else Req0_Valid = 1'b0;
        end
        if (acc1) begin
          if (left1 > 0) begin Req1_SrcA = $urandom; Req1_SrcB = $urandom; end
          else Req1_Valid = 1'b0;
        end
      end
      acc0 = 0; acc1 = 0;
      #1;
      if (Rsp0_Valid) begin
        checks++;
        if (q0.size() == 0 || Rsp0_Result !== q0[0]) begin
          errors++;
          $display("FAIL fair_rsp0 got=%h pending=%0d", Rsp0_Result, q0.size());
        end
        if (q0.size() > 0) void'(q0.pop_front());
      end
      if (Rsp1_Valid) begin
        checks++;
        if (q1.size() == 0 || Rsp1_Result !== q1[0]) begin
          errors++;
          $display("FAIL fair_rsp1 got=%h pending=%0d", Rsp1_Result, q1.size());
        end
        if (q1.size() > 0) void'(q1.pop_front());
      end
      if (Req0_Ready && Req0_Valid && grants < 4) begin
        seq[grants] = 0; grants++; left0--; acc0 = 1;
        q0.push_back(alu_fn(Req0_ALU_Control, Req0_SrcA, Req0_SrcB));
      end
      if (Req1_Ready && Req1_Valid && grants < 4) begin
        seq[grants] = 1; grants++; left1--; acc1 = 1;
        q1.push_back(alu_fn(Req1_ALU_Control, Req1_SrcA, Req1_SrcB));
      end
      done = (grants == 4) && (q0.size() == 0) && (q1.size() == 0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fair_timeout grants=%0d exp=4 pending=%0d/%0d", grants, q0.size(), q1.size());
    end
    checks++;
    if (grants != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin
      errors++;
      $display("FAIL fair_order got=%0d,%0d,%0d,%0d exp=0,1,0,1", seq[0], seq[1], seq[2], seq[3]);
    end
    Req0_Valid = 1'b0; Req1_Valid = 1'b0;
  endtask

  task automatic test_reset_in_issue();
    @(negedge CLK);
    Req1_Valid = 1'b1; Req1_ALU_Control = OP_ADD; Req1_SrcA = 32'h3; Req1_SrcB = 32'h4;
    Rsp1_Ready = 1'b0;
    #1;
    checks++;
    if (Req1_Ready !== 1'b1) begin
      errors++;
      $display("FAIL rii_accept got=%b exp=1", Req1_Ready);
    end
    @(negedge CLK);
    Req1_Valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if ({Rsp0_Valid, Rsp1_Valid, ALU_Control, SrcA, SrcB, Rsp1_Result}
        !== {2'b00, OP_ADD, 96'h0}) begin
      errors++;
      $display("FAIL rii_outputs got=%b%b/%h/%h/%h/%h exp=00/0/0/0/0", Rsp0_Valid, Rsp1_Valid,
               ALU_Control, SrcA, SrcB, Rsp1_Result);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      checks++;
      if (Rsp1_Valid !== 1'b0) begin
        errors++;
        $display("FAIL rii_no_response cycle=%0d got=%b exp=0", i, Rsp1_Valid);
      end
    end
    @(negedge CLK);
    Req0_Valid = 1'b1; Req0_ALU_Control = OP_XOR; Req0_SrcA = 32'hA5A5_A5A5;
    Req0_SrcB = 32'hFFFF_FFFF;
    Req1_Valid = 1'b1; Req1_ALU_Control = OP_OR; Req1_SrcA = 32'h0F0F_0000;
    Req1_SrcB = 32'h0000_F0F0;
    Rsp0_Ready = 1'b1; Rsp1_Ready = 1'b1;
    #1;
    checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b10) begin
      errors++;
      $display("FAIL rii_fresh_grant got=%b exp=10", {Req0_Ready, Req1_Ready});
    end
    @(negedge CLK);
    Req0_Valid = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if ({Rsp0_Valid, Rsp0_Result} !== {1'b1, 32'h5A5A_5A5A}) begin
      errors++;
      $display("FAIL rii_fresh_rsp0 got=%b/%h exp=1/5a5a5a5a", Rsp0_Valid, Rsp0_Result);
    end
    @(negedge CLK);
    @(negedge CLK);
    Req1_Valid = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if ({Rsp1_Valid, Rsp1_Result} !== {1'b1, 32'h0F0F_F0F0}) begin
      errors++;
      $display("FAIL rii_fresh_rsp1 got=%b/%h exp=1/0f0ff0f0", Rsp1_Valid, Rsp1_Result);
    end
  endtask

  // Random traffic against a transaction model: one op in flight at a time,
  // response visible from the second cycle after acceptance until consumed.
  task automatic test_random();
    bit          pend = 0, hold0 = 0, hold1 = 0, acc0 = 0, acc1 = 0;
    bit          pport = 0, last = 1, ev0, ev1, er0, er1, g;
    int          page = 0;
    logic [31:0] pres;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge CLK);
      if (acc0) hold0 = 0;
      if (acc1) hold1 = 0;
      if (!hold0) begin
        Req0_Valid = ($urandom % 2) == 0;
        Req0_ALU_Control = 4'($urandom_range(0, 4));
        Req0_SrcA = $urandom;
        Req0_SrcB = (($urandom % 4) == 0) ? Req0_SrcA : $urandom;
        hold0 = Req0_Valid;
      end
      if (!hold1) begin
        Req1_Valid = ($urandom % 2) == 0;
        Req1_ALU_Control = 4'($urandom_range(0, 4));
        Req1_SrcA = $urandom;
        Req1_SrcB = (($urandom % 4) == 0) ? Req1_SrcA : $urandom;
        hold1 = Req1_Valid;
      end
      Rsp0_Ready = ($urandom % 4) != 0;
      Rsp1_Ready = ($urandom % 4) != 0;
      if (pend) page++;
      #1;
      ev0 = pend && page >= 2 && !pport;
      ev1 = pend && page >= 2 && pport;
      checks++;
      if ({Rsp0_Valid, Rsp1_Valid} !== {ev0, ev1}) begin
        errors++;
        $display("FAIL rand_rsp_valid cyc=%0d got=%b%b exp=%b%b", cyc, Rsp0_Valid, Rsp1_Valid,
                 ev0, ev1);
      end
      if (ev0 || ev1) begin
        checks++;
        if ((ev0 ? {Rsp0_Result, Rsp0_Branch_Condition} : {Rsp1_Result, Rsp1_Branch_Condition})
            !== {pres, pres == 32'h0}) begin
          errors++;
          $display("FAIL rand_rsp_data cyc=%0d port=%0d got=%h exp=%h", cyc, pport,
                   ev0 ? Rsp0_Result : Rsp1_Result, pres);
        end
      end
      g   = (Req0_Valid && Req1_Valid) ? !last : Req1_Valid;
      er0 = !pend && Req0_Valid && !g;
      er1 = !pend && Req1_Valid && g;
      checks++;
      if ({Req0_Ready, Req1_Ready} !== {er0, er1}) begin
        errors++;
        $display("FAIL rand_req_ready cyc=%0d got=%b%b exp=%b%b", cyc, Req0_Ready, Req1_Ready,
                 er0, er1);
      end
      acc0 = er0;
      acc1 = er1;
      if (pend && page >= 2 && (pport ? Rsp1_Ready : Rsp0_Ready)) pend = 0;
      if (er0 || er1) begin
        pend  = 1;
        pport = er1;
        page  = 0;
        last  = er1;
        pres  = er1 ? alu_fn(Req1_ALU_Control, Req1_SrcA, Req1_SrcB)
                    : alu_fn(Req0_ALU_Control, Req0_SrcA, Req0_SrcB);
      end
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_single_op();
    test_contention();
    test_back_pressure();
    test_fairness();
    test_reset_in_issue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
